// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier datapath and its control FSM.
package booth_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int CNT_SIZE_DEF = 4;

  // Step code is {Q[0], Qm1}; 2'b11 behaves like NOP.
  localparam logic [1:0] STEP_NOP = 2'b00;
  localparam logic [1:0] STEP_ADD = 2'b01;
  localparam logic [1:0] STEP_SUB = 2'b10;

endpackage

// File: rtl/booth_addsub.sv
// Combinational W-bit add / subtract / pass selected by the Booth step code.
module booth_addsub
  import booth_pkg::*;
#(
  parameter int W = WIDTH_DEF + 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] m_i,
  input  logic [1:0]   code_i,
  output logic [W-1:0] res_o
);

  always_comb begin
    res_o = a_i;
    case (code_i)
      STEP_ADD: res_o = a_i + m_i;
      STEP_SUB: res_o = a_i - m_i;
      default:  res_o = a_i;
    endcase
  end

endmodule

// File: rtl/booth_datapath.sv
// Booth multiplier register datapath: {A,Q,Qm1} with add/sub and arithmetic-shift
// steps driven by an external control FSM via rst_out / enP / enInp.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int COUNTER_SIZE = CNT_SIZE_DEF
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic [WIDTH-1:0]        multiplicand,
  input  logic [WIDTH-1:0]        multiplier,
  input  logic                    rst_out,
  input  logic                    enP,
  input  logic                    enInp,
  output logic [COUNTER_SIZE-1:0] counter,
  output logic [2*WIDTH-1:0]      product,
  output logic                    done
);

  localparam logic [COUNTER_SIZE-1:0] CNT_MAX = COUNTER_SIZE'(WIDTH);

  // A and M carry one extra bit so -2^(WIDTH-1) operands stay exact.
  logic [WIDTH:0]          a_q, a_d, m_q, m_d, a_step;
  logic [WIDTH-1:0]        q_q, q_d;
  logic                    qm1_q, qm1_d;
  logic [COUNTER_SIZE-1:0] cnt_q, cnt_d;
  logic                    done_q, done_d;

  booth_addsub #(.W(WIDTH + 1)) u_addsub (
    .a_i    (a_q),
    .m_i    (m_q),
    .code_i ({q_q[0], qm1_q}),
    .res_o  (a_step)
  );

  always_comb begin
    a_d    = a_q;
    q_d    = q_q;
    qm1_d  = qm1_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (rst_out) begin
      a_d    = '0;
      q_d    = multiplier;
      qm1_d  = 1'b0;
      m_d    = {multiplicand[WIDTH-1], multiplicand};
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (!done_q) begin
      if (enP) a_d = a_step;
      // Shift consumes the freshly added A when both enables are high.
      if (enInp) begin
        q_d    = {a_d[0], q_q[WIDTH-1:1]};
        qm1_d  = q_q[0];
        a_d    = {a_d[WIDTH], a_d[WIDTH:1]};
        cnt_d  = cnt_q + COUNTER_SIZE'(1);
        done_d = (cnt_d == CNT_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      a_q    <= '0;
      q_q    <= '0;
      qm1_q  <= 1'b0;
      m_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      q_q    <= q_d;
      qm1_q  <= qm1_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign counter = cnt_q;
  assign done    = done_q;
  assign product = {a_q[WIDTH-1:0], q_q};

endmodule

// File: tb/tb_booth_datapath.sv
// Directed bench for booth_datapath: expected products are queued at clear time and
// compared by a monitor whenever done rises.
module tb_booth_datapath;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [7:0]  multiplicand, multiplier;
  logic        rst_out, enP, enInp;
  logic [3:0]  counter;
  logic [15:0] product;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] prod;
    string       name;
  } exp_t;
  exp_t sb[$];

  booth_datapath #(.WIDTH(8), .COUNTER_SIZE(4)) dut (
    .clk          (clk),
    .rst_in       (rst_in),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .rst_out      (rst_out),
    .enP          (enP),
    .enInp        (enInp),
    .counter      (counter),
    .product      (product),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: on each rising done, pop the oldest expectation and compare.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got product %h expected no result", product);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (product !== e.prod || counter !== 4'd8) begin
          errors++;
          $display("FAIL %s: got product %h counter %0d expected product %h counter 8",
                   e.name, product, counter, e.prod);
        end
      end
    end
    done_prev = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp_p,
                      input string name);
    exp_t e;
    e.prod = exp_p;
    e.name = name;
    sb.push_back(e);
    multiplicand = m;
    multiplier   = q;
    rst_out      = 1'b1;
    tick();
    rst_out      = 1'b0;
  endtask

  task automatic run_alt();
    for (int i = 0; i < 8; i++) begin
      enP = 1'b1; enInp = 1'b0; tick();
      enP = 1'b0; enInp = 1'b1; tick();
    end
    enP = 1'b0; enInp = 1'b0;
    tick();
  endtask

  task automatic run_comb(input string name);
    enP = 1'b1; enInp = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk({name, "_not_done_at_7"}, {31'd0, done}, 32'd0);
    tick();
    chk({name, "_done_at_8"}, {31'd0, done}, 32'd1);
    enP = 1'b0; enInp = 1'b0;
    tick();
  endtask

  initial begin
    rst_in = 1'b0; rst_out = 1'b0; enP = 1'b0; enInp = 1'b0;
    multiplicand = '0; multiplier = '0;
    #12;
    chk("reset_product", {16'd0, product}, 32'd0);
    chk("reset_counter", {28'd0, counter}, 32'd0);
    chk("reset_done",    {31'd0, done},    32'd0);
    @(negedge clk);
    rst_in = 1'b1;
    tick();

    // 3 * -4 = -12
    load(8'd3, 8'hFC, 16'hFFF4, "m3_qm4");
    run_alt();
    // Extra pulses after done must not disturb anything.
    for (int i = 0; i < 5; i++) begin
      enP = 1'b1; enInp = 1'b1; tick();
    end
    enP = 1'b0; enInp = 1'b0;
    chk("post_done_counter", {28'd0, counter}, 32'd8);
    chk("post_done_product", {16'd0, product}, 32'h0000FFF4);
    chk("post_done_done",    {31'd0, done},    32'd1);

    // -128 * -128 = 16384
    load(8'h80, 8'h80, 16'h4000, "m128_q128");
    run_alt();
    load(8'd127, 8'd0, 16'h0000, "m127_q0");
    run_alt();
    // 127 * -128 = -16256
    load(8'd127, 8'h80, 16'hC080, "m127_qm128");
    run_alt();
    load(8'hFF, 8'hFF, 16'h0001, "mm1_qm1_comb");
    run_comb("mm1_qm1");
    // -7 * 5 = -35
    load(8'hF9, 8'd5, 16'hFFDD, "mm7_q5_comb");
    run_comb("mm7_q5");

    // Clear wins over simultaneous step enables.
    multiplicand = 8'd5; multiplier = 8'hFD;
    rst_out = 1'b1; enP = 1'b1; enInp = 1'b1;
    tick();
    rst_out = 1'b0; enP = 1'b0; enInp = 1'b0;
    chk("clear_wins_counter", {28'd0, counter}, 32'd0);
    chk("clear_wins_product", {16'd0, product}, 32'h000000FD);
    chk("clear_wins_done",    {31'd0, done},    32'd0);

    // Async reset mid-multiply; no result is queued for the abandoned op.
    multiplicand = 8'd6; multiplier = 8'd7;
    rst_out = 1'b1; tick(); rst_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enP = 1'b1; enInp = 1'b0; tick();
      enP = 1'b0; enInp = 1'b1; tick();
    end
    enP = 1'b0; enInp = 1'b0;
    chk("pre_abort_counter", {28'd0, counter}, 32'd3);
    #2 rst_in = 1'b0;
    #1;
    chk("abort_product", {16'd0, product}, 32'd0);
    chk("abort_counter", {28'd0, counter}, 32'd0);
    chk("abort_done",    {31'd0, done},    32'd0);
    @(negedge clk);
    rst_in = 1'b1;
    tick(); tick();
    chk("post_release_product", {16'd0, product}, 32'd0);
    chk("post_release_counter", {28'd0, counter}, 32'd0);
    load(8'd6, 8'd7, 16'h002A, "m6_q7_after_abort");
    run_alt();

    tick(); tick();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
